multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Moore FSM that sequences a multi-cycle MIPS datapath over shared ALU, unified instruction/data memory, and IR/MDR/ALUOut holding registers.
- Replaces the single-cycle decode: one instruction takes 3–5 states, plus memory wait cycles.
- Memory accesses use a ready handshake.
- Counts retired instructions and flags illegal opcodes.

Parameters:
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- op_code  in  6  IR[31:26], stable from end of FETCH
- func  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if zero
- i_or_d  out  1  memory address: 0=PC, 1=ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load
- mem_to_reg  out  1  write-back source: 1=MDR, 0=ALUOut
- reg_dst  out  1  destination register: 1=rd, 0=rt
- reg_write  out  1  register file write enable
- jal_sign  out  1  write PC+4 to $31
- alu_src_a  out  1  ALU input A: 0=PC, 1=rs
- alu_src_b  out  2  ALU input B: 00=rt, 01=4, 10=ext, 11=ext<<2
- alu_op  out  3  000 add, 001 sub, 010 funct-decoded, 011 and, 100 or, 101 slt
- ext_sign  out  1  1=sign-extend, 0=zero-extend
- pc_source  out  2  00 ALU, 01 ALUOut, 10 jump target, 11 rs
- illegal_op  out  1  one-cycle pulse on unknown opcode
- state  out  4  current state, for debug
- instr_count  out  CNT_W  retired instruction count

Behaviour:
- Reset (async):
  - state=IDLE, instr_count=0.
  - All outputs are Moore decodes of state; all are 0 in IDLE.
  - Reset mid-instruction abandons it; no write strobe may be asserted in the cycle after reset deasserts.
- State encoding: IDLE0 FETCH1 DECODE2 MEMADR3 MEMRD4 MEMWB5 MEMWR6 EXEC7 ALUWB8 IMMEX9 IMMWB10 BRANCH11 JUMP12 JAL13 JR14. Code 15 goes to IDLE.
- Only strobes listed per state are 1; all others are 0. alu_op defaults to 000.
- IDLE: go to FETCH next cycle.
- FETCH:
  - mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01.
  - ir_write=pc_write=mem_ready.
  - Stay while !mem_ready; go to DECODE when ready.
- DECODE: alu_src_a=0, alu_src_b=11, ext_sign=1. Dispatch:
  - 000000 with func 001000 → JR; other func → EXEC.
  - 100011 (lw) or 101011 (sw) → MEMADR.
  - 000100 → BRANCH.
  - 001000, 001100, 001101, 001010 → IMMEX.
  - 000010 → JUMP; 000011 → JAL.
  - Anything else: illegal_op=1 this cycle, → FETCH, not counted.
- MEMADR: alu_src_a=1, alu_src_b=10, ext_sign=1. lw → MEMRD, sw → MEMWR.
- MEMRD: mem_read=1, i_or_d=1. Wait on mem_ready, then → MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0.
- MEMWR: mem_write=1, i_or_d=1. Wait on mem_ready; terminal.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=010. → ALUWB.
- ALUWB: reg_write=1, reg_dst=1.
- IMMEX: alu_src_a=1, alu_src_b=10.
  - addi: alu_op=000, ext_sign=1.
  - andi: alu_op=011, ext_sign=0.
  - ori: alu_op=100, ext_sign=0.
  - slti: alu_op=101, ext_sign=1.
  - → IMMWB.
- IMMWB: reg_write=1, reg_dst=0, alu_op and ext_sign held as in IMMEX.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_write_cond=1, pc_source=01.
- JUMP: pc_write=1, pc_source=10.
- JAL: pc_write=1, pc_source=10, reg_write=1, jal_sign=1.
- JR: pc_write=1, pc_source=11; reg_write=0.
- Terminal states are MEMWB, MEMWR (with mem_ready), ALUWB, IMMWB, BRANCH, JUMP, JAL, JR. Each goes to FETCH and increments instr_count by 1, wrapping at 2^CNT_W.
- Latency in cycles, excluding memory waits: lw 5; sw, R-type, I-type 4; beq, j, jal, jr 3.
- mem_read/mem_write stay asserted throughout a wait and drop the cycle after mem_ready.
- mem_ready outside FETCH/MEMRD/MEMWR is ignored.

Decomposition:
- Shared package holds:
  - state codes
  - opcode and func constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_J, OP_JAL, FN_JR)
  - alu_op, alu_src_b and pc_source encodings
- One natural sub-module: multicycle_outdec, a pure function of state/op_code/func producing all control strobes.
- Next-state logic and counter stay in multicycle_ctrl.

Test Plan:
- Reset held 3 cycles, then released, mem_ready=1 → state 0→1→2; all strobes 0 in IDLE; instr_count=0.
- lw (op 100011), mem_ready=1 → states 1,2,3,4,5,1; mem_to_reg=1 and reg_write=1 only in state 5; instr_count=1.
- sw with mem_ready low 3 cycles in MEMWR → mem_write high 4 cycles, reg_write never 1; instr_count increments once.
- R-type add then jr (func 001000) → add: EXEC alu_op=010, ALUWB reg_dst=1; jr: pc_source=11, reg_write=0; instr_count=2.
- andi (001100) → IMMEX ext_sign=0, alu_op=011; beq → BRANCH pc_write_cond=1, alu_op=001, pc_source=01; jal → reg_write=1, jal_sign=1.
- Opcode 111111 → illegal_op pulses 1 cycle in DECODE, back to FETCH, instr_count unchanged; reset asserted during MEMRD wait → IDLE immediately, mem_read=0.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, opcodes, mux selects.
// No logic latency; constants plus one combinational dispatch helper.
// No handshakes here; backpressure is handled by the FSM in multicycle_ctrl.
package multicycle_ctrl_pkg;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_MEMADR = 4'd3,
      S_MEMRD  = 4'd4,
      S_MEMWB  = 4'd5,
      S_MEMWR  = 4'd6,
      S_EXEC   = 4'd7,
      S_ALUWB  = 4'd8,
      S_IMMEX  = 4'd9,
      S_IMMWB  = 4'd10,
      S_BRANCH = 4'd11,
      S_JUMP   = 4'd12,
      S_JAL    = 4'd13,
      S_JR     = 4'd14
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] FN_JR    = 6'b001000;

   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_FUNCT = 3'b010;
   localparam logic [2:0] ALU_AND   = 3'b011;
   localparam logic [2:0] ALU_OR    = 3'b100;
   localparam logic [2:0] ALU_SLT   = 3'b101;

   localparam logic [1:0] SRCB_RT     = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_EXT    = 2'b10;
   localparam logic [1:0] SRCB_EXT_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;
   localparam logic [1:0] PCSRC_RS     = 2'b11;

   // DECODE dispatch target; S_FETCH doubles as the "illegal opcode" marker
   // since an unknown opcode is dropped and the next fetch starts.
   function automatic state_t decode_dispatch(input logic [5:0] op, input logic [5:0] fn);
      state_t nxt;
      case (op)
         OP_RTYPE:                          nxt = (fn == FN_JR) ? S_JR : S_EXEC;
         OP_LW, OP_SW:                      nxt = S_MEMADR;
         OP_BEQ:                            nxt = S_BRANCH;
         OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: nxt = S_IMMEX;
         OP_J:                              nxt = S_JUMP;
         OP_JAL:                            nxt = S_JAL;
         default:                           nxt = S_FETCH;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/multicycle_ctrl_outdec.sv
// Control-strobe decode of the current controller state (plus opcode/func/mem_ready).
// Purely combinational, zero latency.
// No backpressure of its own; FETCH write strobes follow mem_ready directly.
module multicycle_outdec
   import multicycle_ctrl_pkg::*;
(
   input  state_t      state,
   input  logic [5:0]  op_code,
   input  logic [5:0]  func,
   input  logic        mem_ready,
   output logic        pc_write,
   output logic        pc_write_cond,
   output logic        i_or_d,
   output logic        mem_read,
   output logic        mem_write,
   output logic        ir_write,
   output logic        mem_to_reg,
   output logic        reg_dst,
   output logic        reg_write,
   output logic        jal_sign,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [2:0]  alu_op,
   output logic        ext_sign,
   output logic [1:0]  pc_source,
   output logic        illegal_op
);

   logic [2:0] imm_alu_op;
   logic       imm_ext_sign;

   // ALU operation and extension mode for immediate ops, shared by IMMEX and IMMWB
   always_comb begin
      imm_alu_op   = ALU_ADD;
      imm_ext_sign = 1'b1;
      case (op_code)
         OP_ANDI: begin imm_alu_op = ALU_AND; imm_ext_sign = 1'b0; end
         OP_ORI:  begin imm_alu_op = ALU_OR;  imm_ext_sign = 1'b0; end
         OP_SLTI: begin imm_alu_op = ALU_SLT; imm_ext_sign = 1'b1; end
         default: begin imm_alu_op = ALU_ADD; imm_ext_sign = 1'b1; end
      endcase
   end

   // Per-state strobe decode; everything not named in a state stays 0
   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      jal_sign      = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_RT;
      alu_op        = ALU_ADD;
      ext_sign      = 1'b0;
      pc_source     = PCSRC_ALU;
      illegal_op    = 1'b0;
      case (state)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = SRCB_FOUR;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         S_DECODE: begin
            alu_src_b  = SRCB_EXT_SH;
            ext_sign   = 1'b1;
            illegal_op = (decode_dispatch(op_code, func) == S_FETCH);
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_EXT;
            ext_sign  = 1'b1;
         end
         S_MEMRD: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_FUNCT;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         S_IMMEX: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_EXT;
            alu_op    = imm_alu_op;
            ext_sign  = imm_ext_sign;
         end
         S_IMMWB: begin
            reg_write = 1'b1;
            alu_op    = imm_alu_op;
            ext_sign  = imm_ext_sign;
         end
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = ALU_SUB;
            pc_write_cond = 1'b1;
            pc_source     = PCSRC_ALUOUT;
         end
         S_JUMP: begin
            pc_write  = 1'b1;
            pc_source = PCSRC_JUMP;
         end
         S_JAL: begin
            pc_write  = 1'b1;
            pc_source = PCSRC_JUMP;
            reg_write = 1'b1;
            jal_sign  = 1'b1;
         end
         S_JR: begin
            pc_write  = 1'b1;
            pc_source = PCSRC_RS;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM with retired-instruction counter and illegal-opcode flag.
// 3-5 states per instruction (beq/j/jal/jr 3, sw/R/I 4, lw 5) plus memory waits.
// Stalls in FETCH/MEMRD/MEMWR until mem_ready; requests held high for the whole wait.
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       op_code,
   input  logic [5:0]       func,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic             i_or_d,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             mem_to_reg,
   output logic             reg_dst,
   output logic             reg_write,
   output logic             jal_sign,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [2:0]       alu_op,
   output logic             ext_sign,
   output logic [1:0]       pc_source,
   output logic             illegal_op,
   output logic [3:0]       state,
   output logic [CNT_W-1:0] instr_count
);

   state_t     state_q;
   state_t     state_d;
   logic       retire;
   logic       zero_unused;

   // The zero flag gates the PC inside the datapath via pc_write_cond, not here
   assign zero_unused = zero;
   assign state       = state_q;

   // State register; reset abandons any in-flight instruction
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state selection and retirement detection
   always_comb begin
      state_d = S_IDLE;
      retire  = 1'b0;
      case (state_q)
         S_IDLE:   state_d = S_FETCH;
         S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: state_d = decode_dispatch(op_code, func);
         S_MEMADR: state_d = (op_code == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWR: begin
            state_d = mem_ready ? S_FETCH : S_MEMWR;
            retire  = mem_ready;
         end
         S_EXEC:   state_d = S_ALUWB;
         S_IMMEX:  state_d = S_IMMWB;
         S_MEMWB, S_ALUWB, S_IMMWB, S_BRANCH, S_JUMP, S_JAL, S_JR: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         default:  state_d = S_IDLE;
      endcase
   end

   // Retired-instruction counter, wraps naturally at 2^CNT_W
   always_ff @(posedge clk or posedge reset) begin
      if (reset)       instr_count <= '0;
      else if (retire) instr_count <= instr_count + 1'b1;
   end

   multicycle_outdec u_outdec (
      .state         (state_q),
      .op_code       (op_code),
      .func          (func),
      .mem_ready     (mem_ready),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .i_or_d        (i_or_d),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .ir_write      (ir_write),
      .mem_to_reg    (mem_to_reg),
      .reg_dst       (reg_dst),
      .reg_write     (reg_write),
      .jal_sign      (jal_sign),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .alu_op        (alu_op),
      .ext_sign      (ext_sign),
      .pc_source     (pc_source),
      .illegal_op    (illegal_op)
   );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle vectors of inputs vs. expected state/strobes/count.
// Inputs driven on the falling edge, outputs sampled 1ns later.
// Includes a CNT_W=2 instance fed the same stimulus to observe counter wrap.
module tb_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [5:0]  op_code = 6'd0;
   logic [5:0]  func = 6'd0;
   logic        zero = 1'b0;
   logic        mem_ready = 1'b0;

   logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic        mem_to_reg, reg_dst, reg_write, jal_sign, alu_src_a, ext_sign, illegal_op;
   logic [1:0]  alu_src_b, pc_source;
   logic [2:0]  alu_op;
   logic [3:0]  state;
   logic [31:0] instr_count;

   logic        w_pc_write, w_pc_write_cond, w_i_or_d, w_mem_read, w_mem_write, w_ir_write;
   logic        w_mem_to_reg, w_reg_dst, w_reg_write, w_jal_sign, w_alu_src_a, w_ext_sign, w_illegal_op;
   logic [1:0]  w_alu_src_b, w_pc_source;
   logic [2:0]  w_alu_op;
   logic [3:0]  w_state;
   logic [1:0]  w_instr_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   multicycle_ctrl #(.CNT_W(32)) dut (
      .clk(clk), .reset(reset), .op_code(op_code), .func(func), .zero(zero),
      .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
      .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
      .jal_sign(jal_sign), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .ext_sign(ext_sign), .pc_source(pc_source),
      .illegal_op(illegal_op), .state(state), .instr_count(instr_count)
   );

   multicycle_ctrl #(.CNT_W(2)) dut_w (
      .clk(clk), .reset(reset), .op_code(op_code), .func(func), .zero(zero),
      .mem_ready(mem_ready), .pc_write(w_pc_write), .pc_write_cond(w_pc_write_cond),
      .i_or_d(w_i_or_d), .mem_read(w_mem_read), .mem_write(w_mem_write), .ir_write(w_ir_write),
      .mem_to_reg(w_mem_to_reg), .reg_dst(w_reg_dst), .reg_write(w_reg_write),
      .jal_sign(w_jal_sign), .alu_src_a(w_alu_src_a), .alu_src_b(w_alu_src_b),
      .alu_op(w_alu_op), .ext_sign(w_ext_sign), .pc_source(w_pc_source),
      .illegal_op(w_illegal_op), .state(w_state), .instr_count(w_instr_count)
   );

   // Control word layout used for both expected and actual values
   function automatic logic [19:0] mk(input logic pcw, input logic pcc, input logic iod,
                                      input logic mr, input logic mw, input logic irw,
                                      input logic m2r, input logic rd, input logic rw,
                                      input logic jal, input logic asa, input logic [1:0] asb,
                                      input logic [2:0] aop, input logic ext,
                                      input logic [1:0] psrc, input logic ill);
      return {pcw, pcc, iod, mr, mw, irw, m2r, rd, rw, jal, asa, asb, aop, ext, psrc, ill};
   endfunction

   logic [19:0] act_cw;
   assign act_cw = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                    mem_to_reg, reg_dst, reg_write, jal_sign, alu_src_a, alu_src_b,
                    alu_op, ext_sign, pc_source, illegal_op};

   typedef struct {
      logic        rst;
      logic [5:0]  op;
      logic [5:0]  fn;
      logic        rdy;
      logic [3:0]  exp_state;
      logic [19:0] exp_cw;
      logic [31:0] exp_cnt;
   } vec_t;

   vec_t vecs[40];
   int   nvec = 0;

   logic [19:0] C_IDLE, C_FETCH_W, C_FETCH_R, C_DECODE, C_DECODE_ILL, C_MEMADR, C_MEMRD;
   logic [19:0] C_MEMWB, C_MEMWR, C_EXEC, C_ALUWB, C_IMMEX_AND, C_IMMWB_AND, C_BRANCH;
   logic [19:0] C_JUMP, C_JAL, C_JR;

   task automatic push(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                       input logic rdy, input logic [3:0] st, input logic [19:0] cw,
                       input logic [31:0] cnt);
      vecs[nvec].rst = rst;       vecs[nvec].op = op;
      vecs[nvec].fn = fn;         vecs[nvec].rdy = rdy;
      vecs[nvec].exp_state = st;  vecs[nvec].exp_cw = cw;
      vecs[nvec].exp_cnt = cnt;
      nvec++;
   endtask

   // One cycle: drive on falling edge, sample 1ns later, compare everything
   task automatic step(input int idx, input logic rst, input logic [5:0] op,
                       input logic [5:0] fn, input logic rdy, input logic [3:0] st,
                       input logic [19:0] cw, input logic [31:0] cnt);
      @(negedge clk);
      reset = rst; op_code = op; func = fn; mem_ready = rdy;
      #1;
      checks++;
      if (state !== st) begin
         errors++;
         $display("FAIL state step %0d: got %0d want %0d", idx, state, st);
      end
      checks++;
      if (act_cw !== cw) begin
         errors++;
         $display("FAIL ctrl_word step %0d: got %05h want %05h", idx, act_cw, cw);
      end
      checks++;
      if (instr_count !== cnt) begin
         errors++;
         $display("FAIL instr_count step %0d: got %0d want %0d", idx, instr_count, cnt);
      end
      checks++;
      if (w_instr_count !== cnt[1:0]) begin
         errors++;
         $display("FAIL wrap_count step %0d: got %0d want %0d", idx, w_instr_count, cnt[1:0]);
      end
   endtask

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, ANDI = 6'b001100;
   localparam logic [5:0] BEQ = 6'b000100, JAL = 6'b000011, J = 6'b000010, BAD = 6'b111111;
   localparam logic [5:0] F_ADD = 6'b100000, F_JR = 6'b001000;

   int mw_cycles;

   initial begin
      //               pcw pcc iod mr mw irw m2r rd rw jal asa asb    aop     ext psrc   ill
      C_IDLE       = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 2'b00, 0);
      C_FETCH_W    = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b01, 3'b000, 0, 2'b00, 0);
      C_FETCH_R    = mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b01, 3'b000, 0, 2'b00, 0);
      C_DECODE     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b000, 1, 2'b00, 0);
      C_DECODE_ILL = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b000, 1, 2'b00, 1);
      C_MEMADR     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b000, 1, 2'b00, 0);
      C_MEMRD      = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 2'b00, 0);
      C_MEMWB      = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 2'b00, 3'b000, 0, 2'b00, 0);
      C_MEMWR      = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 2'b00, 0);
      C_EXEC       = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b010, 0, 2'b00, 0);
      C_ALUWB      = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 3'b000, 0, 2'b00, 0);
      C_IMMEX_AND  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b011, 0, 2'b00, 0);
      C_IMMWB_AND  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 3'b011, 0, 2'b00, 0);
      C_BRANCH     = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b001, 0, 2'b01, 0);
      C_JUMP       = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 2'b10, 0);
      C_JAL        = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 3'b000, 0, 2'b10, 0);
      C_JR         = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 2'b11, 0);

      //   rst op    fn     rdy state cw            cnt
      push(1, LW,   6'd0,  1,  0,  C_IDLE,       0);
      push(1, LW,   6'd0,  1,  0,  C_IDLE,       0);
      push(1, LW,   6'd0,  1,  0,  C_IDLE,       0);
      push(0, LW,   6'd0,  1,  0,  C_IDLE,       0);
      push(0, LW,   6'd0,  1,  1,  C_FETCH_R,    0);
      push(0, LW,   6'd0,  1,  2,  C_DECODE,     0);
      push(0, LW,   6'd0,  1,  3,  C_MEMADR,     0);
      push(0, LW,   6'd0,  1,  4,  C_MEMRD,      0);
      push(0, LW,   6'd0,  1,  5,  C_MEMWB,      0);
      push(0, RT,   F_ADD, 1,  1,  C_FETCH_R,    1);
      push(0, RT,   F_ADD, 1,  2,  C_DECODE,     1);
      push(0, RT,   F_ADD, 1,  7,  C_EXEC,       1);
      push(0, RT,   F_ADD, 1,  8,  C_ALUWB,      1);
      push(0, RT,   F_JR,  1,  1,  C_FETCH_R,    2);
      push(0, RT,   F_JR,  1,  2,  C_DECODE,     2);
      push(0, RT,   F_JR,  1,  14, C_JR,         2);
      push(0, ANDI, 6'd0,  1,  1,  C_FETCH_R,    3);
      push(0, ANDI, 6'd0,  1,  2,  C_DECODE,     3);
      push(0, ANDI, 6'd0,  1,  9,  C_IMMEX_AND,  3);
      push(0, ANDI, 6'd0,  1,  10, C_IMMWB_AND,  3);
      push(0, BEQ,  6'd0,  1,  1,  C_FETCH_R,    4);
      push(0, BEQ,  6'd0,  1,  2,  C_DECODE,     4);
      push(0, BEQ,  6'd0,  1,  11, C_BRANCH,     4);
      push(0, JAL,  6'd0,  1,  1,  C_FETCH_R,    5);
      push(0, JAL,  6'd0,  1,  2,  C_DECODE,     5);
      push(0, JAL,  6'd0,  1,  13, C_JAL,        5);
      push(0, BAD,  6'd0,  1,  1,  C_FETCH_R,    6);
      push(0, BAD,  6'd0,  1,  2,  C_DECODE_ILL, 6);
      push(0, BAD,  6'd0,  0,  1,  C_FETCH_W,    6);
      push(0, BAD,  6'd0,  0,  1,  C_FETCH_W,    6);

      for (int i = 0; i < nvec; i++)
         step(i, vecs[i].rst, vecs[i].op, vecs[i].fn, vecs[i].rdy,
              vecs[i].exp_state, vecs[i].exp_cw, vecs[i].exp_cnt);

      // sw with three wait cycles in MEMWR: mem_write must stay high 4 cycles, no reg_write
      step(100, 0, SW, 6'd0, 1, 1, C_FETCH_R, 6);
      step(101, 0, SW, 6'd0, 1, 2, C_DECODE,  6);
      step(102, 0, SW, 6'd0, 1, 3, C_MEMADR,  6);
      mw_cycles = 0;
      for (int k = 0; k < 4; k++) begin
         step(103 + k, 0, SW, 6'd0, (k == 3), 6, C_MEMWR, 6);
         if (mem_write === 1'b1) mw_cycles++;
      end
      checks++;
      if (mw_cycles != 4) begin
         errors++;
         $display("FAIL sw_mem_write_len: got %0d want 4", mw_cycles);
      end

      // j retires the 8th instruction: the 2-bit counter wraps 3 -> 0
      step(110, 0, J,  6'd0, 1, 1,  C_FETCH_R, 7);
      step(111, 0, J,  6'd0, 1, 2,  C_DECODE,  7);
      step(112, 0, J,  6'd0, 1, 12, C_JUMP,    7);

      // lw stalled in MEMRD, then reset mid-wait: immediate IDLE, mem_read drops
      step(120, 0, LW, 6'd0, 1, 1, C_FETCH_R, 8);
      step(121, 0, LW, 6'd0, 1, 2, C_DECODE,  8);
      step(122, 0, LW, 6'd0, 0, 3, C_MEMADR,  8);
      step(123, 0, LW, 6'd0, 0, 4, C_MEMRD,   8);
      step(124, 0, LW, 6'd0, 0, 4, C_MEMRD,   8);
      step(125, 1, LW, 6'd0, 0, 0, C_IDLE,    0);
      step(126, 0, LW, 6'd0, 0, 0, C_IDLE,    0);
      step(127, 0, LW, 6'd0, 0, 1, C_FETCH_W, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
